// File: rtl/led7_pkg.sv
// Shared types, segment decode table and helpers for the multiplexed 7-segment driver.
package led7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Active-high {a,b,c,d,e,f,g}, indexed by nibble value 0..F.
  localparam seg7_t SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic nibble_is_zero(input logic [3:0] n);
    return n == 4'd0;
  endfunction

endpackage

// File: rtl/led7_hex_decode.sv
// Combinational nibble to active-high segment decoder; codes 10-15 blank unless hex_en.
module led7_hex_decode
  import led7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (hex_en || (nibble < 4'd10)) seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/led7_scan.sv
// Multiplexed N-digit seven-segment scanner with tear-free frame-aligned updates,
// leading-zero blanking and configurable pin polarities.
module led7_scan
  import led7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYC      = 2,
  parameter int unsigned HEX_EN         = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int unsigned PW      = $clog2(REFRESH_DIV);
  localparam int unsigned IW      = $clog2(DIGITS);
  localparam logic        SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic        AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic        HEX_ON  = (HEX_EN != 0);

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  boundary;
  logic [4*DIGITS-1:0]   pend_val;
  logic [4*DIGITS-1:0]   shad_val;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     shad_dp;
  logic                  pend;
  logic [DIGITS-1:0]     lz_mask;
  logic [DIGITS-1:0]     an_on;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  lz_sel;
  logic                  lz_run;
  seg7_t                 dec_seg;
  seg7_t                 seg_on;

  always_comb begin
    tick     = (pcnt == PW'(REFRESH_DIV - 1));
    boundary = tick && (idx == IW'(DIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Shadow only changes on the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      shad_val <= '0;
      shad_dp  <= '0;
      pend     <= 1'b0;
    end else if (load && boundary) begin
      shad_val <= value;
      shad_dp  <= dp_in;
      pend     <= 1'b0;
    end else begin
      if (boundary && pend) begin
        shad_val <= pend_val;
        shad_dp  <= pend_dp;
        pend     <= 1'b0;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend     <= 1'b1;
      end
    end
  end

  // Blank digit k>0 while every nibble from the top down to k is zero.
  always_comb begin
    lz_mask = '0;
    lz_run  = blank_lz;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run & nibble_is_zero(shad_val[4*k +: 4]);
      lz_mask[k] = lz_run;
    end
  end

  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    an_on  = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib      = shad_val[4*k +: 4];
        dp_sel   = shad_dp[k];
        lz_sel   = lz_mask[k];
        an_on[k] = (pcnt >= PW'(BLANK_CYC));
      end
    end
  end

  led7_hex_decode u_dec (
    .nibble (nib),
    .hex_en (HEX_ON),
    .seg    (dec_seg)
  );

  always_comb seg_on = lz_sel ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segments   <= {7{SEG_INV}};
      dp         <= SEG_INV;
      anodes     <= {DIGITS{AN_INV}};
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_on ^ {7{SEG_INV}};
      dp         <= dp_sel ^ SEG_INV;
      anodes     <= an_on ^ {DIGITS{AN_INV}};
      frame_done <= boundary;
    end
  end

endmodule

// File: doc/led7_scan.md
# led7_scan

Multiplexed N-digit seven-segment display driver, parametrised successor of the single-digit BCD decoder. It latches a packed multi-nibble value, scans the digits one at a time with a programmable refresh divider, and decodes each nibble to segment drive. Decoding supports optional hex (A–F) and leading-zero blanking. It sits between the numeric datapath (counters, calculators) and the board's common-anode/common-cathode display pins.

## Interface
- DIGITS, 4: number of digits, ≥2; digit 0 is the rightmost and least significant.
- REFRESH_DIV, 50000: clock cycles per digit slot, ≥2.
- BLANK_CYC, 2: anti-ghost cycles at the start of each slot during which all anodes are inactive; 0 ≤ BLANK_CYC < REFRESH_DIV.
- HEX_EN, 1: 1 = decode 10–15 as A b C d E F; 0 = codes 10–15 are blank.
- SEG_ACTIVE_LOW, 1: segment/dp polarity at the pins.
- AN_ACTIVE_LOW, 1: anode polarity at the pins.
- clk  in  1  system clock. All logic is on the rising edge.
- rst_n  in  1  reset. **Synchronous, active-low.**
- load  in  1  capture `value`/`dp_in` this cycle.
- value  in  4*DIGITS  packed nibbles; nibble k is [4k+3:4k] and feeds digit k.
- dp_in  in  DIGITS  decimal-point enable per digit, active-high.
- blank_lz  in  1  leading-zero blanking enable; sampled live, not latched.
- segments  out  7  {a,b,c,d,e,f,g}, with a at bit 6.
- dp  out  1  decimal point.
- anodes  out  DIGITS  digit enables; bit k drives digit k.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- **Prescaler** `pcnt`:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - `tick` is asserted when pcnt == REFRESH_DIV-1.
- **Digit index** `idx`:
  - Advances on `tick`, wrapping DIGITS-1 → 0.
  - The frame boundary is `tick` with idx == DIGITS-1. `frame_done` pulses on that cycle.
- **Tear-free update**:
  - `load` captures value/dp_in into a pending register and sets `pend`.
  - At the frame boundary, if `pend`, pending is copied to shadow and `pend` clears.
  - Repeated loads before a boundary: the last one wins.
  - A `load` on the boundary cycle itself goes straight to shadow and leaves `pend` clear.
- **Decode** (active-high internal form; listed as the active-low pin pattern a..g):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100
  - 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100
  - A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000
  - Blank is 1111111.
- **Leading-zero blanking**:
  - When blank_lz=1, digit k>0 is blank if shadow nibbles DIGITS-1 down to k are all zero.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- **Output polarity**: segments/dp are inverted when SEG_ACTIVE_LOW=0; anodes are inverted when AN_ACTIVE_LOW=0.
- **Reset values**:
  - pcnt=0, idx=0, shadow=0, pending=0, pend=0.
  - anodes all inactive, segments blank, dp off, frame_done=0.

## Timing
- segments, dp, anodes and frame_done are registered: one cycle of latency from the pcnt/idx state that selects them.
- Slot k lasts REFRESH_DIV cycles. Anode k is active only for pcnt ≥ BLANK_CYC, i.e. (REFRESH_DIV − BLANK_CYC) cycles per slot, seen one cycle later at the pins.
- A frame is DIGITS·REFRESH_DIV cycles.
- Latency from load to the value first appearing is at most one frame plus one slot plus 1 cycle.
- rst_n low on any cycle, including mid-slot: the outputs show their reset values on the next edge and scanning restarts at digit 0.
- `load` during reset is ignored.

## Structure
- Package `led7_pkg` holds:
  - `seg7_t` (logic [6:0]);
  - the constants SEG_BLANK and the 16-entry decode table;
  - the function `nibble_is_zero`.
- Sub-module `led7_hex_decode` (combinational; nibble, hex_en → seg7_t, active-high) is instantiated once on the muxed nibble.
- Top-level: prescaler, index counter, pending/shadow registers, LZ mask generation, output registers.

## Test plan
Benches run with DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, active-low polarities unless stated.
- **Reset**: hold rst_n=0 for 3 cycles, then release → during reset anodes=1111, segments=1111111, dp=1. In the first slot anodes=1110 (from the 2nd cycle of the slot), segments=0000001, frame_done at cycle 16.
- **Scan order**: load 16'h1234 with dp_in=4'b0100 → after commit, slots show:
  - 1110 / 1001100
  - 1101 / 0000110
  - 1011 / 0010010, dp=0
  - 0111 / 1001111
- **Leading-zero blanking**:
  - 16'h0050, blank_lz=1 → digits 3 and 2 are 1111111, digit 1 is 0100100, digit 0 is 0000001.
  - 16'h0000 → only digit 0 lit.
  - blank_lz=0 → all digits show 0000001.
- **Hex mode**:
  - 16'hABCD, HEX_EN=1 → digit0 1000010, digit1 0110001, digit2 1100000, digit3 0001000.
  - HEX_EN=0 → all four digits 1111111.
- **Tear-free update**:
  - Load 16'h1111 and then 16'h2222 mid-frame → the current frame stays on the old value, and the next frame is entirely 2 (0010010), never mixed.
  - Load 16'h3333 on the boundary cycle → the following frame shows 3s.
- **Mid-operation reset**: pulse rst_n low for 1 cycle in slot 2 → the next cycle shows reset values, shadow=0, and scanning restarts at anodes=1110.
